// File: rtl/bm_mac_window_drain_pkg.sv
// Shared widths, defaults and FSM encoding for the MAC window-drain block.
package bm_mac_window_drain_pkg;

  localparam int BITS0      = 9;
  localparam int BITS2      = 18;
  localparam int DECIM_DEF  = 8;
  localparam int DEPTH_DEF  = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    RUN   = 2'd2
  } state_t;

endpackage

// File: rtl/bm_drain_fifo.sv
// Parameterised first-word-fall-through FIFO; head reads 0 while empty.
// A push while full is accepted only when a pop happens on the same edge.
module bm_drain_fifo #(
  parameter int W     = 18,
  parameter int DEPTH = 4
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   level;
  logic          do_pop;
  logic          do_push;

  assign empty   = (level == '0);
  assign full    = (level == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = empty ? '0 : mem[rd_ptr];

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // NOTE: storage has no reset; level gates every read, so stale words are never visible.
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/bm_mac_window_drain.sv
// Windows a free-running wrapping accumulator into per-window deltas and buffers them.
// Optional build macro BM_DRAIN_ZERO_SKIP_EN: zero-valued window deltas are not pushed.
module bm_mac_window_drain
  import bm_mac_window_drain_pkg::*;
#(
  parameter int BITS2 = bm_mac_window_drain_pkg::BITS2,
  parameter int DECIM = DECIM_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [BITS2-1:0] acc_in,
  input  logic             acc_vld,
  input  logic             start,
  input  logic             stop,
  output logic [BITS2-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             ovf
);

  localparam int            CW       = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DECIM - 1);

  state_t           state;
  state_t           state_nxt;
  logic [BITS2-1:0] base;
  logic [CW-1:0]    cnt;
  logic [BITS2-1:0] delta;
  logic             window_done;
  logic             push_req;
  logic             pop;
  logic             full;
  logic             empty;

  // Unsigned subtraction wraps modulo 2^BITS2, matching the accumulator itself.
  assign delta       = acc_in - base;
  assign window_done = (state == RUN) && acc_vld && !stop && (cnt == CNT_LAST);

`ifdef BM_DRAIN_ZERO_SKIP_EN
  assign push_req = window_done && (delta != '0);
`else
  assign push_req = window_done;
`endif

  assign out_valid = !empty;
  assign pop       = out_valid && out_ready;
  assign busy      = (state != IDLE);

  // NOTE: next-state defaults come first so no path through the case can infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = PRIME;
      PRIME: begin
        if (stop)         state_nxt = IDLE;
        else if (acc_vld) state_nxt = RUN;
      end
      RUN:     if (stop) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      base  <= '0;
      cnt   <= '0;
      ovf   <= 1'b0;
    end else begin
      state <= state_nxt;

      if (state == PRIME && acc_vld) begin
        base <= acc_in;
        cnt  <= '0;
      end else if (state == RUN && acc_vld) begin
        if (cnt == CNT_LAST) begin
          base <= acc_in;
          cnt  <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end

      // A result is lost only when the FIFO is full and nothing leaves on this edge.
      if (state == IDLE && start)   ovf <= 1'b0;
      else if (push_req && full && !pop) ovf <= 1'b1;
    end
  end

  bm_drain_fifo #(
    .W     (BITS2),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset_n   (reset_n),
    .push      (push_req),
    .push_data (delta),
    .pop       (pop),
    .full      (full),
    .empty     (empty),
    .head      (out_data)
  );

endmodule

// File: tb/tb_bm_mac_window_drain.sv
// Scoreboard bench for bm_mac_window_drain: a behavioural model queues expected deltas
// as samples are driven; a negedge monitor pops and compares on each handshake.
module tb_bm_mac_window_drain;

  localparam int BITS2 = 18;
  localparam int DECIM = 8;
  localparam int DEPTH = 4;

  logic             clock = 1'b0;
  logic             reset_n = 1'b0;
  logic [BITS2-1:0] acc_in = '0;
  logic             acc_vld = 1'b0;
  logic             start = 1'b0;
  logic             stop = 1'b0;
  logic [BITS2-1:0] out_data;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic             busy;
  logic             ovf;

  int errors = 0;
  int checks = 0;

  logic [BITS2-1:0] exp_q [$];
  int               m_state = 0;  // 0 idle, 1 prime, 2 run
  int               m_cnt   = 0;
  int               m_level = 0;
  logic [BITS2-1:0] m_base  = '0;
  bit               m_ovf   = 1'b0;
  logic [BITS2-1:0] acc     = '0;

  bm_mac_window_drain #(
    .BITS2 (BITS2),
    .DECIM (DECIM),
    .DEPTH (DEPTH)
  ) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .acc_in    (acc_in),
    .acc_vld   (acc_vld),
    .start     (start),
    .stop      (stop),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .ovf       (ovf)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Drive one cycle and advance the model across the coming edge.
  task automatic step(input bit vld, input logic [BITS2-1:0] data,
                      input bit st, input bit sp, input bit rdy);
    bit               pop, push, accepted, ovf_n;
    int               ns;
    logic [BITS2-1:0] delta;
    acc_vld   = vld;
    acc_in    = data;
    start     = st;
    stop      = sp;
    out_ready = rdy;
    pop      = rdy && (m_level != 0);
    push     = 1'b0;
    accepted = 1'b0;
    ovf_n    = m_ovf;
    ns       = m_state;
    delta    = '0;
    case (m_state)
      0: if (st) begin ns = 1; ovf_n = 1'b0; end
      1: begin
        if (sp) ns = 0;
        else if (vld) begin m_base = data; m_cnt = 0; ns = 2; end
      end
      default: begin
        if (sp) ns = 0;
        else if (vld) begin
          if (m_cnt == DECIM - 1) begin
            delta  = data - m_base;
            m_base = data;
            m_cnt  = 0;
            push   = 1'b1;
`ifdef BM_DRAIN_ZERO_SKIP_EN
            if (delta == '0) push = 1'b0;
`endif
          end else begin
            m_cnt++;
          end
        end
      end
    endcase
    if (push) begin
      if (m_level < DEPTH || pop) begin
        exp_q.push_back(delta);
        accepted = 1'b1;
      end else begin
        ovf_n = 1'b1;
      end
    end
    @(posedge clock);
    #1;
    m_state = ns;
    m_ovf   = ovf_n;
    m_level = m_level + int'(accepted) - int'(pop);
  endtask

  task automatic ramp(input int n, input int inc, input bit rdy);
    for (int i = 0; i < n; i++) begin
      step(1'b1, acc, 1'b0, 1'b0, rdy);
      acc = acc + BITS2'(inc);
    end
  endtask

  task automatic rnd(input int n, input bit rdy);
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 3) == 0) step(1'b0, BITS2'($urandom), 1'b0, 1'b0, rdy);
      acc = acc + BITS2'($urandom_range(1, 300));
      step(1'b1, acc, 1'b0, 1'b0, rdy);
    end
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, 1'b0, rdy);
  endtask

  always @(negedge clock) begin
    if (reset_n) begin
      check("valid", out_valid, m_level != 0);
      check("busy", busy, m_state != 0);
      check("ovf", ovf, m_ovf);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("pop_unexpected", 1, 0);
        else                   check("data", out_data, exp_q.pop_front());
      end else if (!out_valid) begin
        check("data_empty", out_data, 0);
      end
    end
  end

  initial begin
    #20000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state.
    #12;
    check("rst_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_ovf", ovf, 0);
    check("rst_data", out_data, 0);
    reset_n = 1'b1;
    @(posedge clock);
    #1;

    // Ramp of 10 per sample: every window yields 80; then stall the consumer.
    step(1'b0, '0, 1'b1, 1'b0, 1'b1);
    acc = '0;
    ramp(25, 10, 1'b1);
    ramp(8, 10, 1'b0);
    check("ramp_latency", out_data, 80);
    for (int i = 0; i < 2; i++) begin
      step(1'b0, '0, 1'b0, 1'b0, 1'b0);
      check("head_hold", out_data, 80);
      check("head_valid", out_valid, 1);
    end
    step(1'b0, '0, 1'b0, 1'b1, 1'b1);
    idle(2, 1'b1);

    // Wraparound of the accumulator across a window.
    step(1'b0, '0, 1'b1, 1'b0, 1'b1);
    step(1'b1, 18'h3FFF0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) begin
      step(1'b1, BITS2'($urandom), 1'b0, 1'b0, 1'b0);
      step(1'b0, BITS2'($urandom), 1'b0, 1'b0, 1'b0);
    end
    step(1'b1, 18'h00010, 1'b0, 1'b0, 1'b0);
    check("wrap", out_data, 18'h00020);
    step(1'b0, '0, 1'b0, 1'b1, 1'b1);
    idle(2, 1'b1);

    // Five windows into a four-deep FIFO with no consumer: one dropped.
    step(1'b0, '0, 1'b1, 1'b0, 1'b0);
    acc = '0;
    ramp(41, 10, 1'b0);
    check("full_valid", out_valid, 1);
    check("full_ovf", ovf, 1);
    step(1'b0, '0, 1'b0, 1'b1, 1'b0);
    idle(6, 1'b1);
    check("drained", out_valid, 0);
    step(1'b0, '0, 1'b1, 1'b0, 1'b0);
    check("ovf_clear", ovf, 0);

    // Full FIFO, window completes on the same edge as a pop.
    step(1'b1, acc, 1'b0, 1'b0, 1'b0);
    rnd(32, 1'b0);
    check("pre_full", out_valid, 1);
    rnd(7, 1'b0);
    acc = acc + 18'd77;
    step(1'b1, acc, 1'b0, 1'b0, 1'b1);
    check("pushpop_ovf", ovf, 0);
    step(1'b0, '0, 1'b0, 1'b1, 1'b0);
    idle(6, 1'b1);

    // stop mid-window at cnt=5 with an older entry still queued.
    step(1'b0, '0, 1'b1, 1'b0, 1'b0);
    step(1'b1, acc, 1'b0, 1'b0, 1'b0);
    rnd(8, 1'b0);
    rnd(5, 1'b0);
    acc = acc + 18'd5;
    step(1'b1, acc, 1'b0, 1'b1, 1'b0);
    check("stop_busy", busy, 0);
    check("stop_keeps", out_valid, 1);
    idle(3, 1'b1);

    // Asynchronous reset mid-RUN with the FIFO non-empty.
    step(1'b0, '0, 1'b1, 1'b0, 1'b0);
    step(1'b1, acc, 1'b0, 1'b0, 1'b0);
    rnd(11, 1'b0);
    #3;
    reset_n = 1'b0;
    #1;
    check("arst_valid", out_valid, 0);
    check("arst_busy", busy, 0);
    check("arst_data", out_data, 0);
    exp_q.delete();
    m_state = 0; m_cnt = 0; m_level = 0; m_base = '0; m_ovf = 1'b0;
    acc_vld = 1'b0; start = 1'b0; stop = 1'b0; out_ready = 1'b0;
    @(posedge clock);
    #2;
    reset_n = 1'b1;
    @(posedge clock);
    #1;

    // Constant accumulator: three zero windows.
    step(1'b0, '0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 25; i++) step(1'b1, 18'h00123, 1'b0, 1'b0, 1'b0);
`ifdef BM_DRAIN_ZERO_SKIP_EN
    check("zskip_valid", out_valid, 0);
`else
    check("zero_valid", out_valid, 1);
    check("zero_head", out_data, 0);
`endif
    step(1'b0, '0, 1'b0, 1'b1, 1'b0);
    idle(5, 1'b1);

    check("sb_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
